systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 188 ++++++++++++++++++
 tb/tb_systolic_feeder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Skewed operand feeder for an N x N output-stationary systolic array.
// Holds A and B tiles, streams them diagonally, then waits for the array to finish.

module systolic_feeder_lane #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int TW   = 3,
  parameter int LANE = 0
) (
  input  logic                   en_i,
  input  logic [TW-1:0]          t_i,
  input  logic [N-1:0][DW-1:0]   elem_i,
  output logic                   v_o,
  output logic [DW-1:0]          d_o
);
  // Lane LANE carries element k on beat t = LANE + k; the row/column skew lives here.
  always_comb begin
    v_o = 1'b0;
    d_o = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        if (t_i == TW'(LANE + k)) begin
          v_o = 1'b1;
          d_o = elem_i[k];
        end
      end
    end
  end
endmodule

module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int TO = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [N*DW-1:0]      wr_data,
  input  logic                 start,
  input  logic                 arr_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 clr,
  output logic [N*DW-1:0]      a_left_flat,
  output logic [N-1:0]         a_v_row_flat,
  output logic [N*DW-1:0]      b_top_flat,
  output logic [N-1:0]         b_v_col_flat
);
  localparam int TW = $clog2(2 * N);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CLR    = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  localparam logic [TW-1:0] T_LAST  = TW'(2 * N - 2);
  localparam logic [7:0]    WD_LAST = 8'(TO - 1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [7:0]    wd_q, wd_d;
  logic          busy_q, done_q, done_d, err_q, err_d, clr_q;

  // a_q[i][k] = A[i][k], b_q[k][j] = B[k][j]
  logic [N-1:0][N-1:0][DW-1:0] a_q, b_q;
  logic [N-1:0][N-1:0][DW-1:0] b_col;

  logic [N-1:0][DW-1:0] al_q, al_d, bt_q, bt_d;
  logic [N-1:0]         av_q, av_d, bv_q, bv_d;
  logic                 stream_d;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    wd_d    = wd_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          err_d   = 1'b0;
        end
      end
      CLR: begin
        state_d = STREAM;
        t_d     = '0;
      end
      STREAM: begin
        if (t_q == T_LAST) begin
          state_d = WAIT;
          wd_d    = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: begin
        // arr_done wins over a watchdog expiry landing in the same cycle
        if (arr_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
    endcase
  end

  assign stream_d = (state_d == STREAM);

  for (genvar j = 0; j < N; j++) begin : g_bcol
    for (genvar k = 0; k < N; k++) begin : g_bk
      assign b_col[j][k] = b_q[k][j];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_feeder_lane #(.N(N), .DW(DW), .TW(TW), .LANE(i)) u_a (
      .en_i   (stream_d),
      .t_i    (t_d),
      .elem_i (a_q[i]),
      .v_o    (av_d[i]),
      .d_o    (al_d[i])
    );
    systolic_feeder_lane #(.N(N), .DW(DW), .TW(TW), .LANE(i)) u_b (
      .en_i   (stream_d),
      .t_i    (t_d),
      .elem_i (b_col[i]),
      .v_o    (bv_d[i]),
      .d_o    (bt_d[i])
    );
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      al_q    <= '0;
      av_q    <= '0;
      bt_q    <= '0;
      bv_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      wd_q    <= wd_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
      clr_q   <= (state_d == CLR);
      al_q    <= al_d;
      av_q    <= av_d;
      bt_q    <= bt_d;
      bv_q    <= bv_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (wr_en && state_q == IDLE) begin
      if (!wr_sel) a_q[wr_row] <= wr_data;
      else         b_q[wr_row] <= wr_data;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign clr          = clr_q;
  assign a_left_flat  = al_q;
  assign a_v_row_flat = av_q;
  assign b_top_flat   = bt_q;
  assign b_v_col_flat = bv_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder against a matrix-level skew model.

module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam int NW = N * DW;
  localparam int RW = $clog2(N);
  localparam int BW = 2 * NW + 2 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [RW-1:0] wr_row = '0;
  logic [NW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          arr_done = 1'b0;
  logic          busy, done, err, clr;
  logic [NW-1:0] a_left_flat, b_top_flat;
  logic [N-1:0]  a_v_row_flat, b_v_col_flat;

  systolic_feeder #(.N(N), .DW(DW), .TO(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .start        (start),
    .arr_done     (arr_done),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .clr          (clr),
    .a_left_flat  (a_left_flat),
    .a_v_row_flat (a_v_row_flat),
    .b_top_flat   (b_top_flat),
    .b_v_col_flat (b_v_col_flat)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  logic [DW-1:0] A_m [N][N];
  logic [DW-1:0] B_m [N][N];

  // Beat t of the skewed stream: lane i carries element k = t - i when 0 <= k < N.
  function automatic logic [BW-1:0] exp_beat(int t);
    logic [NW-1:0] al, bt;
    logic [N-1:0]  av, bv;
    al = '0; bt = '0; av = '0; bv = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = t - i;
      if (k >= 0 && k < N) begin
        av[i] = 1'b1;
        bv[i] = 1'b1;
        al[i*DW +: DW] = A_m[i][k];
        bt[i*DW +: DW] = B_m[k][i];
      end
    end
    return {al, av, bt, bv};
  endfunction

  function automatic logic [BW-1:0] obs_beat();
    return {a_left_flat, a_v_row_flat, b_top_flat, b_v_col_flat};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic sel, input int r, input logic [NW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = RW'(r); wr_data = d;
    step();
    wr_en = 1'b0;
    for (int e = 0; e < N; e++) begin
      if (!sel) A_m[r][e] = d[e*DW +: DW];
      else      B_m[r][e] = d[e*DW +: DW];
    end
  endtask

  task automatic load_random();
    for (int r = 0; r < N; r++) begin
      load_row(1'b0, r, {$urandom, $urandom});
      load_row(1'b1, r, {$urandom, $urandom});
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A_m[i][k] = '0;
        B_m[i][k] = '0;
      end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Streams out the remaining run and hands back arr_done on the first WAIT cycle.
  task automatic finish_run();
    for (int t = 0; t < 2*N-1; t++) step();
    step();
    arr_done = 1'b1;
    step();
    arr_done = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, done, err, clr, obs_beat()} !== '0)
      $display("FAIL reset_init got %h exp 0", {busy, done, err, clr, obs_beat()});
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    clear_model();
    load_random();
    do_start();
    step(); step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, err, clr, obs_beat()} !== '0)
      $display("FAIL reset_mid_stream got %h exp 0", {busy, done, err, clr, obs_beat()});
    else pass_cnt++;
    #2 rst_n = 1'b1;
    step(); step();
    total++;
    if ({busy, done, err} !== 3'b000)
      $display("FAIL reset_release busy/done/err got %b exp 000", {busy, done, err});
    else pass_cnt++;
    clear_model();
    do_start();
    for (int t = 0; t < 2*N-1; t++) begin
      step();
      total++;
      if (obs_beat() !== exp_beat(t))
        $display("FAIL reset_cleared_buf t=%0d got %h exp %h", t, obs_beat(), exp_beat(t));
      else pass_cnt++;
    end
    step();
    arr_done = 1'b1;
    step();
    arr_done = 1'b0;
  endtask

  task automatic test_skew();
    for (int i = 0; i < N; i++) begin
      logic [NW-1:0] ra, rb;
      for (int k = 0; k < N; k++) begin
        ra[k*DW +: DW] = DW'(4*i + k + 1);
        rb[k*DW +: DW] = (i == k) ? DW'(1) : DW'(0);
      end
      load_row(1'b0, i, ra);
      load_row(1'b1, i, rb);
    end
    do_start();
    total++;
    if ({clr, busy, a_v_row_flat, b_v_col_flat} !== {2'b11, 8'h00})
      $display("FAIL skew_clr got %b exp 1100000000", {clr, busy, a_v_row_flat, b_v_col_flat});
    else pass_cnt++;
    for (int t = 0; t < 2*N-1; t++) begin
      step();
      total++;
      if (obs_beat() !== exp_beat(t))
        $display("FAIL skew_beat t=%0d got %h exp %h", t, obs_beat(), exp_beat(t));
      else pass_cnt++;
      if (t == 0) begin
        total++;
        if ({a_v_row_flat, b_v_col_flat, a_left_flat[7:0]} !== {4'h1, 4'h1, 8'd1})
          $display("FAIL skew_t0 got %h exp 1101", {a_v_row_flat, b_v_col_flat, a_left_flat[7:0]});
        else pass_cnt++;
      end
      if (t == 3) begin
        total++;
        if ({a_v_row_flat, a_left_flat, b_v_col_flat} !== {4'hF, 32'h0D0A0704, 4'hF})
          $display("FAIL skew_t3 got %h exp f0d0a0704f", {a_v_row_flat, a_left_flat, b_v_col_flat});
        else pass_cnt++;
      end
      if (t == 6) begin
        total++;
        if ({a_v_row_flat, a_left_flat, b_v_col_flat, b_top_flat} !== {4'h8, 32'h10000000, 4'h8, 32'h01000000})
          $display("FAIL skew_t6 got %h exp 8100000008 01000000",
                   {a_v_row_flat, a_left_flat, b_v_col_flat, b_top_flat});
        else pass_cnt++;
      end
    end
    for (int w = 0; w < 3; w++) begin
      step();
      total++;
      if ({busy, clr, done, a_v_row_flat} !== {3'b100, 4'h0})
        $display("FAIL skew_wait%0d got %b exp 1000000", w, {busy, clr, done, a_v_row_flat});
      else pass_cnt++;
    end
    arr_done = 1'b1;
    step();
    arr_done = 1'b0;
    total++;
    if ({done, busy, err} !== 3'b100)
      $display("FAIL complete_done got %b exp 100", {done, busy, err});
    else pass_cnt++;
    do_start();
    total++;
    if ({clr, busy, done} !== 3'b110)
      $display("FAIL back_to_back_clr got %b exp 110", {clr, busy, done});
    else pass_cnt++;
    finish_run();
    total++;
    if (done !== 1'b1) $display("FAIL back_to_back_done got %b exp 1", done);
    else pass_cnt++;
  endtask

  task automatic test_ignore();
    int extra;
    load_random();
    do_start();
    for (int t = 0; t < 2*N-1; t++) begin
      step();
      wr_en = 1'b0; start = 1'b0;
      total++;
      if (obs_beat() !== exp_beat(t))
        $display("FAIL ignore_beat t=%0d got %h exp %h", t, obs_beat(), exp_beat(t));
      else pass_cnt++;
      if (t == 0) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_data = {N{8'h07}}; start = 1'b1;
      end
    end
    step();
    arr_done = 1'b1;
    step();
    arr_done = 1'b0;
    total++;
    if (done !== 1'b1) $display("FAIL ignore_done got %b exp 1", done);
    else pass_cnt++;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (busy || clr) extra++;
    end
    total++;
    if (extra !== 0) $display("FAIL ignore_no_rerun busy cycles got %0d exp 0", extra);
    else pass_cnt++;
    do_start();
    for (int t = 0; t < 2*N-1; t++) begin
      step();
      total++;
      if (obs_beat() !== exp_beat(t))
        $display("FAIL ignore_rerun t=%0d got %h exp %h", t, obs_beat(), exp_beat(t));
      else pass_cnt++;
    end
    step();
    arr_done = 1'b1;
    step();
    arr_done = 1'b0;
  endtask

  task automatic test_watchdog();
    int cnt, done_seen;
    do_start();
    done_seen = 0;
    for (int t = 0; t < 2*N-1; t++) begin
      step();
      arr_done = (t == 2);
      if (done) done_seen++;
    end
    arr_done = 1'b0;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (done) done_seen++;
      if (!busy) break;
      cnt++;
    end
    total++;
    if (cnt !== TO) $display("FAIL watchdog_wait_cycles got %0d exp %0d", cnt, TO);
    else pass_cnt++;
    total++;
    if ({err, busy, done_seen != 0} !== 3'b100)
      $display("FAIL watchdog_err got err=%b busy=%b done_seen=%0d exp 1 0 0", err, busy, done_seen);
    else pass_cnt++;
    arr_done = 1'b1;
    step();
    arr_done = 1'b0;
    step();
    total++;
    if ({done, busy, err} !== 3'b001)
      $display("FAIL watchdog_idle_arr_done got %b exp 001", {done, busy, err});
    else pass_cnt++;
    do_start();
    total++;
    if ({err, clr} !== 2'b01) $display("FAIL watchdog_err_clear got %b exp 01", {err, clr});
    else pass_cnt++;
    finish_run();
  endtask

  task automatic test_signed();
    for (int r = 0; r < N; r++) begin
      load_row(1'b0, r, {N{8'h80}});
      load_row(1'b1, r, {N{8'h7F}});
    end
    do_start();
    for (int t = 0; t < 2*N-1; t++) begin
      step();
      total++;
      if (obs_beat() !== exp_beat(t))
        $display("FAIL signed_beat t=%0d got %h exp %h", t, obs_beat(), exp_beat(t));
      else pass_cnt++;
      if (t == N-1) begin
        total++;
        if ({a_left_flat, b_top_flat} !== {{N{8'h80}}, {N{8'h7F}}})
          $display("FAIL signed_full got %h exp 808080807f7f7f7f", {a_left_flat, b_top_flat});
        else pass_cnt++;
      end
    end
    step();
    arr_done = 1'b1;
    step();
    arr_done = 1'b0;
  endtask

  task automatic test_random_runs();
    for (int run = 0; run < 4; run++) begin
      int dly;
      load_random();
      dly = $urandom_range(0, 10);
      do_start();
      for (int t = 0; t < 2*N-1; t++) begin
        step();
        total++;
        if (obs_beat() !== exp_beat(t))
          $display("FAIL random_beat run=%0d t=%0d got %h exp %h", run, t, obs_beat(), exp_beat(t));
        else pass_cnt++;
      end
      for (int w = 0; w <= dly; w++) step();
      arr_done = 1'b1;
      step();
      arr_done = 1'b0;
      total++;
      if ({done, busy, err} !== 3'b100)
        $display("FAIL random_done run=%0d got %b exp 100", run, {done, busy, err});
      else pass_cnt++;
      step();
      total++;
      if (done !== 1'b0) $display("FAIL random_done_width run=%0d got %b exp 0", run, done);
      else pass_cnt++;
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_skew();
    test_ignore();
    test_watchdog();
    test_signed();
    test_random_runs();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
